// File: rtl/btb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : btb_pkg
// Purpose : Shared types, counter encodings and the PC index/tag split used
//           by the branch target buffer.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package btb_pkg;

  // 2-bit direction counter encodings
  localparam logic [1:0] CNT_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] CNT_WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] CNT_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CNT_ST  = 2'b11;  // strongly taken

  // One table entry. The tag field is sized for the smallest legal table;
  // bits above the real tag width are always zero and drop out in synthesis.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  cnt;
  } btb_entry_t;

  // Result of splitting a PC into table index and tag (both zero-extended).
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] tag;
  } btb_split_t;

  // What a resolved branch does to its table entry.
  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,  // miss and not taken: leave table alone
    ACT_TRAIN = 2'd1,  // hit: train counter, maybe refresh target
    ACT_ALLOC = 2'd2   // miss and taken: install a new entry
  } btb_act_t;

  // index = pc[idx_w+1:2], tag = pc[31:idx_w+2]; pc[1:0] is ignored.
  function automatic btb_split_t btb_split(input logic [31:0] pc,
                                           input int unsigned idx_w);
    btb_split_t s;
    s.idx = (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    s.tag = pc >> (idx_w + 2);
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btb_predictor_if.sv
`default_nettype none
// ============================================================================
// Module  : btb_predictor_if
// Purpose : Fetch-lookup, EX-training and perf-counter bundle of the BTB.
// Ports   : flush_all, pcF, upd_* (core -> BTB);
//           btb_hitF, btb_predict_takenF, btb_targetF, perf_* (BTB -> core)
//           master = core/pipeline side, slave = predictor side.
// Revision: 1.0  initial release
// ============================================================================
interface btb_predictor_if #(
  parameter int PERF_W = 32
);
  logic              flush_all;
  logic [31:0]       pcF;
  logic              btb_hitF;
  logic              btb_predict_takenF;
  logic [31:0]       btb_targetF;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_is_jump;
  logic              upd_mispredict;
  logic [PERF_W-1:0] perf_hits;
  logic [PERF_W-1:0] perf_mispredicts;

  modport master (
    output flush_all, pcF,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
           upd_mispredict,
    input  btb_hitF, btb_predict_takenF, btb_targetF,
    input  perf_hits, perf_mispredicts
  );

  modport slave (
    input  flush_all, pcF,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
           upd_mispredict,
    output btb_hitF, btb_predict_takenF, btb_targetF,
    output perf_hits, perf_mispredicts
  );
endinterface
`default_nettype wire

// File: rtl/btb_predictor_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter2
// Purpose : Combinational 2-bit saturating up/down counter step.
// Ports   : cur_i   current counter value
//           taken_i 1 = count up, 0 = count down
//           next_o  next counter value, clamped to 2'b00..2'b11
// Revision: 1.0  initial release
// ============================================================================
module sat_counter2
  import btb_pkg::*;
(
  input  logic [1:0] cur_i,
  input  logic       taken_i,
  output logic [1:0] next_o
);

  always_comb begin
    next_o = cur_i;
    if (taken_i) begin
      if (cur_i != CNT_ST) next_o = cur_i + 2'b01;
    end else begin
      if (cur_i != CNT_SNT) next_o = cur_i - 2'b01;
    end
  end

endmodule
`default_nettype wire

// File: rtl/btb_predictor.sv
`default_nettype none
// ============================================================================
// Module  : btb_predictor
// Purpose : Direct-mapped branch target buffer with 2-bit direction counters.
//           Zero-latency lookup at fetch, trained by EX resolution, with hit
//           and mispredict performance counters.
// Ports   : clk  rising-edge clock
//           rst  asynchronous active-high reset
//           bus  btb_predictor_if.slave (lookup, update, perf counters)
// Revision: 1.0  initial release
// ============================================================================
module btb_predictor
  import btb_pkg::*;
#(
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         PERF_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  btb_predictor_if.slave     bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t table_q [ENTRIES];

  // --------------------------------------------------------------------------
  // Fetch lookup (reads current state only, so a same-cycle update is not
  // visible until the next cycle)
  // --------------------------------------------------------------------------
  btb_split_t       look_split;
  logic [IDX_W-1:0] look_idx;
  btb_entry_t       look_entry;
  logic             look_hit;

  always_comb begin
    look_split = btb_split(bus.pcF, IDX_W);
    look_idx   = look_split.idx[IDX_W-1:0];
    look_entry = table_q[look_idx];
    look_hit   = look_entry.valid && (look_entry.tag == look_split.tag);
  end

  assign bus.btb_hitF           = look_hit;
  assign bus.btb_predict_takenF = look_hit && look_entry.cnt[1];
  assign bus.btb_targetF        = look_hit ? look_entry.target : 32'b0;

  // --------------------------------------------------------------------------
  // EX training: work out the one entry that may change and its new value
  // --------------------------------------------------------------------------
  btb_split_t       upd_split;
  logic [IDX_W-1:0] upd_idx;
  btb_entry_t       upd_entry;
  logic             upd_hit;
  logic [1:0]       upd_cnt_step;
  btb_act_t         upd_act;
  btb_entry_t       entry_d;

  always_comb begin
    upd_split = btb_split(bus.upd_pc, IDX_W);
    upd_idx   = upd_split.idx[IDX_W-1:0];
    upd_entry = table_q[upd_idx];
    upd_hit   = upd_entry.valid && (upd_entry.tag == upd_split.tag);
  end

  sat_counter2 u_sat_counter2 (
    .cur_i   (upd_entry.cnt),
    .taken_i (bus.upd_taken),
    .next_o  (upd_cnt_step)
  );

  always_comb begin
    upd_act = ACT_NONE;
    if (bus.upd_valid) begin
      if (upd_hit)            upd_act = ACT_TRAIN;
      else if (bus.upd_taken) upd_act = ACT_ALLOC;
    end
  end

  always_comb begin
    entry_d = upd_entry;
    case (upd_act)
      ACT_TRAIN: begin
        // Jumps are always taken, so pin them at strongly-taken.
        entry_d.cnt = bus.upd_is_jump ? CNT_ST : upd_cnt_step;
        if (bus.upd_taken) entry_d.target = bus.upd_target;
      end
      ACT_ALLOC: begin
        entry_d.valid  = 1'b1;
        entry_d.tag    = upd_split.tag;
        entry_d.target = bus.upd_target;
        entry_d.cnt    = bus.upd_is_jump ? CNT_ST : CNT_WT;
      end
      default: entry_d = upd_entry;
    endcase
  end

  // Upper bits of the zero-extended index fields are constant zero.
  logic unused_idx_bits;
  assign unused_idx_bits = ^{look_split.idx, upd_split.idx};

  // --------------------------------------------------------------------------
  // Table state. flush_all has priority over a same-cycle update.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid  <= 1'b0;
        table_q[i].tag    <= '0;
        table_q[i].target <= '0;
        table_q[i].cnt    <= CNT_INIT;
      end
    end else if (bus.flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
        table_q[i].cnt   <= CNT_INIT;
      end
    end else if (upd_act != ACT_NONE) begin
      table_q[upd_idx] <= entry_d;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters (cleared by rst only, wrap naturally)
  // --------------------------------------------------------------------------
  logic [PERF_W-1:0] perf_hits_q, perf_hits_d;
  logic [PERF_W-1:0] perf_misp_q, perf_misp_d;

  always_comb begin
    perf_hits_d = perf_hits_q;
    perf_misp_d = perf_misp_q;
    if (look_hit)                            perf_hits_d = perf_hits_q + 1'b1;
    if (bus.upd_valid && bus.upd_mispredict) perf_misp_d = perf_misp_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hits_q <= '0;
      perf_misp_q <= '0;
    end else begin
      perf_hits_q <= perf_hits_d;
      perf_misp_q <= perf_misp_d;
    end
  end

  assign bus.perf_hits        = perf_hits_q;
  assign bus.perf_mispredicts = perf_misp_q;

endmodule
`default_nettype wire

// File: tb/tb_btb_predictor.sv
`default_nettype none
// ============================================================================
// Module  : tb_btb_predictor
// Purpose : Self-checking bench for btb_predictor: directed scenarios then
//           randomized traffic against a behavioural table model.
// Ports   : none
// Revision: 1.0  initial release
// ============================================================================
module tb_btb_predictor;

  localparam int ENTRIES = 16;
  localparam int PERF_W  = 32;

  logic clk = 1'b0;
  logic rst;

  btb_predictor_if #(.PERF_W(PERF_W)) bus ();

  btb_predictor #(
    .ENTRIES  (ENTRIES),
    .CNT_INIT (2'b01),
    .PERF_W   (PERF_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: table indexed by word address modulo ENTRIES.
  logic        m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  logic [31:0] m_hits;
  logic [31:0] m_misp;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] mtag(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic void mlook(input logic [31:0] pc, output logic h,
                                output logic pt, output logic [31:0] t);
    int i = midx(pc);
    h  = m_valid[i] && (m_tag[i] == mtag(pc));
    pt = h && (m_cnt[i] >= 2);
    t  = h ? m_tgt[i] : 32'h0;
  endfunction

  task automatic mreset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
    m_hits = 0;
    m_misp = 0;
  endtask

  task automatic mupdate();
    int i = midx(bus.upd_pc);
    if (m_valid[i] && m_tag[i] == mtag(bus.upd_pc)) begin
      if (bus.upd_is_jump)    m_cnt[i] = 3;
      else if (bus.upd_taken) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
      else                    m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
      if (bus.upd_taken) m_tgt[i] = bus.upd_target;
    end else if (bus.upd_taken) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = mtag(bus.upd_pc);
      m_tgt[i]   = bus.upd_target;
      m_cnt[i]   = bus.upd_is_jump ? 3 : 2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic check_all(input string name);
    logic h, pt;
    logic [31:0] t;
    mlook(bus.pcF, h, pt, t);
    chk({name, ".hit"},   {31'b0, bus.btb_hitF},           {31'b0, h});
    chk({name, ".ptk"},   {31'b0, bus.btb_predict_takenF}, {31'b0, pt});
    chk({name, ".tgt"},   bus.btb_targetF,                 t);
    chk({name, ".phits"}, bus.perf_hits,                   m_hits);
    chk({name, ".pmisp"}, bus.perf_mispredicts,            m_misp);
  endtask

  // Advance the model with the inputs now on the bus, then take the edge.
  task automatic tick();
    logic h, pt;
    logic [31:0] t;
    if (!rst) begin
      mlook(bus.pcF, h, pt, t);
      if (h) m_hits = m_hits + 1;
      if (bus.upd_valid && bus.upd_mispredict) m_misp = m_misp + 1;
      if (bus.flush_all) begin
        for (int i = 0; i < ENTRIES; i++) begin
          m_valid[i] = 1'b0;
          m_cnt[i]   = 1;
        end
      end else if (bus.upd_valid) begin
        mupdate();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_all      = 1'b0;
    bus.upd_valid      = 1'b0;
    bus.upd_pc         = 32'h0;
    bus.upd_taken      = 1'b0;
    bus.upd_target     = 32'h0;
    bus.upd_is_jump    = 1'b0;
    bus.upd_mispredict = 1'b0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk,
                         input logic [31:0] tg, input logic jp,
                         input logic mp);
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = pc;
    bus.upd_taken      = tk;
    bus.upd_target     = tg;
    bus.upd_is_jump    = jp;
    bus.upd_mispredict = mp;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] mkpc();
    logic [31:0] tg, ix, lo;
    tg = $urandom % 3;
    if (($urandom % 8) == 0) tg = tg + 32'h0010_0000;
    ix = $urandom % 4;
    lo = $urandom % 4;
    return tg * (4 * ENTRIES) + ix * 4 + lo;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    idle();
    rst     = 1'b1;
    bus.pcF = 32'h100;
    mreset();
    settle();
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---------------- allocate ----------------
    set_upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    settle();
    check_all("alloc_pre");
    tick();
    idle();
    settle();
    check_all("alloc");
    chk("alloc.hit_c", {31'b0, bus.btb_hitF},           32'd1);
    chk("alloc.ptk_c", {31'b0, bus.btb_predict_takenF}, 32'd1);
    chk("alloc.tgt_c", bus.btb_targetF,                 32'h80);

    // ---------------- saturation toward not-taken ----------------
    for (int k = 0; k < 3; k++) begin
      set_upd(32'h100, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      tick();
      idle();
      settle();
      check_all("sat_nt");
      chk("sat_nt.hit_c", {31'b0, bus.btb_hitF},           32'd1);
      chk("sat_nt.ptk_c", {31'b0, bus.btb_predict_takenF}, 32'd0);
      chk("sat_nt.tgt_c", bus.btb_targetF,                 32'h80);
    end
    // from 00 one taken step reaches only 01
    set_upd(32'h100, 1'b1, 32'h84, 1'b0, 1'b0);
    tick();
    idle();
    settle();
    check_all("sat_up1");
    chk("sat_up1.ptk_c", {31'b0, bus.btb_predict_takenF}, 32'd0);
    chk("sat_up1.tgt_c", bus.btb_targetF,                 32'h84);

    // ---------------- alias on index 0 ----------------
    set_upd(32'h140, 1'b1, 32'h200, 1'b0, 1'b0);
    tick();
    idle();
    bus.pcF = 32'h100;
    settle();
    check_all("alias_old");
    chk("alias_old.hit_c", {31'b0, bus.btb_hitF}, 32'd0);
    bus.pcF = 32'h142;
    settle();
    check_all("alias_new");
    chk("alias_new.tgt_c", bus.btb_targetF, 32'h200);

    // ---------------- same-cycle update, no bypass ----------------
    bus.pcF = 32'h140;
    set_upd(32'h140, 1'b1, 32'h300, 1'b0, 1'b0);
    settle();
    check_all("same_cyc");
    chk("same_cyc.tgt_c", bus.btb_targetF, 32'h200);
    tick();
    idle();
    settle();
    check_all("same_nxt");
    chk("same_nxt.tgt_c", bus.btb_targetF, 32'h300);

    // ---------------- async reset mid-cycle ----------------
    rst = 1'b1;
    mreset();
    #1;
    check_all("async_rst");
    chk("async_rst.hit_c", {31'b0, bus.btb_hitF}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---------------- perf counters and flush ----------------
    bus.pcF = 32'h0;
    set_upd(32'h40, 1'b1, 32'h44, 1'b1, 1'b0);
    tick();
    bus.pcF = 32'h40;
    set_upd(32'h1000, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    set_upd(32'h1000, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    bus.pcF = 32'h0;
    settle();
    check_all("perf");
    chk("perf.hits_c", bus.perf_hits,        32'd3);
    chk("perf.misp_c", bus.perf_mispredicts, 32'd2);
    bus.flush_all = 1'b1;
    set_upd(32'h80, 1'b1, 32'h90, 1'b0, 1'b0);
    tick();
    idle();
    bus.pcF = 32'h40;
    settle();
    check_all("flush_a");
    chk("flush_a.hit_c", {31'b0, bus.btb_hitF}, 32'd0);
    bus.pcF = 32'h80;
    settle();
    check_all("flush_b");
    chk("flush_b.hit_c",  {31'b0, bus.btb_hitF}, 32'd0);
    chk("flush_b.hits_c", bus.perf_hits,         32'd3);
    chk("flush_b.misp_c", bus.perf_mispredicts,  32'd2);

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 600; n++) begin
      bus.pcF = mkpc();
      if (($urandom % 2) == 1) begin
        set_upd(mkpc(), 1'($urandom % 2), $urandom, 1'(($urandom % 4) == 0),
                1'($urandom % 2));
      end else begin
        idle();
        bus.upd_mispredict = 1'($urandom % 2);
      end
      bus.flush_all = (($urandom % 64) == 0);
      settle();
      check_all("rand");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Sits in the IF stage. It produces the per-fetch prediction triple (hit, predict-taken, target) that travels IF -> IF/ID -> ID/EX.
- It is trained from EX-stage branch/jump resolution.
- Also keeps hit and mispredict performance counters for the bench and software.

Parameters:
- ENTRIES, 16, number of table entries; power of two, >= 2.
- CNT_INIT, 2'b01, counter value loaded on reset/invalidate (weakly not-taken).
- PERF_W, 32, width of performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush_all  in  1  synchronous invalidate of every entry (e.g. after fence.i).
- pcF  in  32  fetch PC to look up.
- btb_hitF  out  1  valid entry with matching tag at pcF.
- btb_predict_takenF  out  1  btb_hitF AND counter[1].
- btb_targetF  out  32  stored target when btb_hitF, else 32'b0.
- upd_valid  in  1  EX resolved a branch/jump this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual target (ignored when not taken).
- upd_is_jump  in  1  JAL/JALR (unconditional).
- upd_mispredict  in  1  EX detected a direction or target mispredict.
- perf_hits  out  PERF_W  lookups that hit since reset.
- perf_mispredicts  out  PERF_W  upd_valid && upd_mispredict events since reset.

Behaviour:
- Address split: IDX_W = $clog2(ENTRIES).
  - index = pc[IDX_W+1:2].
  - tag = pc[31:IDX_W+2].
  - pc[1:0] is ignored.
- Per-entry state: valid, tag, target[31:0], cnt[1:0].
- Lookup is purely combinational from current state; zero-cycle latency.
- Reset (async) and flush_all (sync):
  - all valid <= 0 and all cnt <= CNT_INIT.
  - All outputs therefore read 0 after reset.
  - Perf counters clear on rst only, not on flush_all.
- Update, on the rising edge when upd_valid=1:
  - Hit at upd_pc (valid and tag match):
    - upd_is_jump: cnt <= 2'b11.
    - Otherwise: cnt saturating +1 if taken, -1 if not taken; saturates at 2'b11 and 2'b00.
    - If taken: target <= upd_target. If not taken: target unchanged.
  - Miss and taken: allocate/replace the entry.
    - valid <= 1, tag <= new tag, target <= upd_target.
    - cnt <= 2'b11 if upd_is_jump, else 2'b10.
  - Miss and not taken: no change.
- Simultaneous lookup and update to the same index in one cycle:
  - The lookup returns pre-update contents; no bypass.
  - The new value is visible the following cycle.
- flush_all and upd_valid in the same cycle: flush_all wins and the table ends fully invalid.
- perf_hits increments each cycle btb_hitF=1 while not in reset.
- Both perf counters wrap modulo 2^PERF_W.
- upd_mispredict is ignored when upd_valid=0.
- Reset mid-operation clears state immediately, independent of clk.

Decomposition:
- Shared package btb_pkg:
  - btb_entry_t struct (valid, tag, target, cnt).
  - Counter constants CNT_SNT=2'b00, CNT_WNT=2'b01, CNT_WT=2'b10, CNT_ST=2'b11.
  - Function for the index/tag split.
- Sub-module sat_counter2: combinational 2-bit saturating inc/dec. Inputs cur, taken; output next.

Test Plan (ENTRIES=16):
- Reset: assert rst with pcF=0x100 -> btb_hitF=0, btb_predict_takenF=0, btb_targetF=0, perf counters 0.
- Allocate: upd pc=0x100, taken=1, target=0x80, is_jump=0 -> next cycle pcF=0x100 gives hit=1, predict_taken=1, target=0x80, cnt=10.
- Saturation: two further not-taken updates on 0x100 -> cnt 01 then 00, predict_taken=0 with hit=1. A third not-taken keeps cnt=00.
- Alias: pc 0x140 (same index 0, tag 5 vs 4), taken, target 0x200 -> 0x100 now misses; 0x140 hits with target 0x200.
- Same-cycle update: update to 0x140 with target 0x300 while pcF=0x140 -> that cycle target=0x200, next cycle 0x300.
- Flush/perf: after 3 hitting lookups and 2 mispredict updates, perf_hits=3 and perf_mispredicts=2. Assert flush_all together with upd_valid -> all lookups miss and perf counters are unchanged.
